// File: rtl/mem_io_responder_if.sv
// Processor memory-port bundle: initiator drives the request, responder returns data/ready.
interface mem_io_responder_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_ena, mem_wr_ena,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_ena, mem_wr_ena,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-port responder: fixed-latency word array plus one I/O word at 0xFFFF
// (reads return the switches, writes load the hex-display register).
module mem_io_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_io_responder_if.slave   bus,
  input  logic [15:0]         sw_i,
  output logic [15:0]         hex_display_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_wr;
  logic [15:0] r_rdata;
  logic [15:0] r_hex;
  logic        r_ready;
  logic        r_busy;
  logic [15:0] r_mem [0:(2**ADDR_W)-1];

  logic              w_fire_resp;
  logic [15:0]       w_addr;
  logic [15:0]       w_wdata;
  logic              w_wr;
  logic              w_io;
  logic              w_mapped;
  logic [ADDR_W-1:0] w_idx;

  // The access completes on the edge entering RESP. With LATENCY=1 that is the
  // accepting edge itself, so the live inputs stand in for the capture registers.
  always_comb begin
    w_fire_resp = ((r_state == S_IDLE) && bus.mem_ena && (LATENCY == 1)) ||
                  ((r_state == S_WAIT) && (r_cnt == 4'(LATENCY - 1)));
    w_addr      = (r_state == S_IDLE) ? bus.mem_addr   : r_addr;
    w_wdata     = (r_state == S_IDLE) ? bus.mem_wdata  : r_wdata;
    w_wr        = (r_state == S_IDLE) ? bus.mem_wr_ena : r_wr;
    w_io        = (w_addr == 16'hFFFF);
    w_mapped    = !w_io && ({16'd0, w_addr} < (32'd1 << ADDR_W));
    w_idx       = w_addr[ADDR_W-1:0];
  end

  // Control FSM with registered ready/busy/read-data/hex outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_hex   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.mem_ena) begin
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wdata;
            r_wr    <= bus.mem_wr_ena;
            r_busy  <= 1'b1;
            if (LATENCY > 1) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'd1;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'(LATENCY - 1)) r_state <= S_RESP;
          else                          r_cnt   <= r_cnt + 4'd1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_fire_resp) begin
        r_ready <= 1'b1;
        if (!w_wr)
          r_rdata <= w_io ? sw_i : (w_mapped ? r_mem[w_idx] : 16'h0000);
        if (w_wr && w_io)
          r_hex <= w_wdata;
      end
    end
  end

  // Array write port; contents are deliberately not reset, and unmapped writes drop.
  always_ff @(posedge clk) begin
    if (!reset && w_fire_resp && w_wr && w_mapped)
      r_mem[w_idx] <= w_wdata;
  end

  assign bus.mem_rdata  = r_rdata;
  assign bus.mem_ready  = r_ready;
  assign hex_display_o  = r_hex;
  assign busy_o         = r_busy;

endmodule
